// File: rtl/riscv_pkg.sv
// Shared RV32 opcode/funct3 constants and the memory/write-back stage state type.
package riscv_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_I     = 5'b00100;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_S     = 5'b01000;
  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_B     = 5'b11000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_J     = 5'b11011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Store byte-enable / lane replication and load lane extraction with sign/zero extension.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_result_o
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (funct3_i)
      F3_B: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted  = ld_data_i >> {ld_addr_lo_i, 3'b000};
    ld_byte     = ld_shifted[7:0];
    ld_half     = ld_addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    ld_result_o = ld_data_i;
    case (funct3_i)
      F3_B:    ld_result_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_result_o = {24'h000000, ld_byte};
      F3_H:    ld_result_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_result_o = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory/write-back stage: req/ack data-bus accesses and register-file write-back.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_ppl,
  input  logic [31:0] ALU_ppl,
  input  logic [31:0] rdata2_forwarded_ppl,
  input  logic [31:0] PC_ppl,
  output logic        reg_wr,
  output logic [31:0] wdata,
  output logic        stall,
  output logic        mem_err,
  output logic        misalign,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  input  logic [31:0] dbus_rdata
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [1:0]           off_q, off_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          swdata_q, swdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 misal_q, misal_d;

  logic [4:0]  opc;
  logic [2:0]  funct3;
  logic        rd_nz, is_load, is_store, is_mem, misal_hit;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, ld_result;

  assign opc      = instruction_ppl[6:2];
  assign funct3   = instruction_ppl[14:12];
  assign rd_nz    = |instruction_ppl[11:7];
  assign is_load  = (instruction_ppl[1:0] == 2'b11) && (opc == OPC_LOAD);
  assign is_store = (instruction_ppl[1:0] == 2'b11) && (opc == OPC_S);
  assign is_mem   = is_load || is_store;

`ifdef MISALIGN_TRAP_EN
  assign misal_hit = ((funct3[1:0] == 2'b01) && ALU_ppl[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALU_ppl[1:0] != 2'b00));
`else
  assign misal_hit = 1'b0;
`endif

  // Store lanes use the live address (IDLE); load lanes use the offset latched in IDLE.
  lsu_lane_align u_align (
    .funct3_i     (funct3),
    .st_addr_lo_i (ALU_ppl[1:0]),
    .st_data_i    (rdata2_forwarded_ppl),
    .st_be_o      (al_be),
    .st_wdata_o   (al_wdata),
    .ld_addr_lo_i (off_q),
    .ld_data_i    (rdata_q),
    .ld_result_o  (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      swdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      we_q     <= we_d;
      be_q     <= be_d;
      swdata_q <= swdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      misal_q  <= misal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    off_d    = off_q;
    we_d     = we_q;
    be_d     = be_q;
    swdata_d = swdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    misal_d  = misal_q;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          addr_d   = {ALU_ppl[31:2], 2'b00};
          off_d    = ALU_ppl[1:0];
          we_d     = is_store;
          be_d     = al_be;
          swdata_d = al_wdata;
          err_d    = 1'b0;
          misal_d  = misal_hit;
          cnt_d    = '0;
          state_d  = misal_hit ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          err_d   = dbus_err;
          state_d = RESP;
        end else if ((BUS_TIMEOUT != 0) && (cnt_d == TIMEOUT_W'(BUS_TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though IDLE decode is combinational.
  always_comb begin
    reg_wr   = 1'b0;
    wdata    = '0;
    stall    = 1'b0;
    mem_err  = 1'b0;
    misalign = 1'b0;
    dbus_req = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            stall = 1'b1;
          end else if (instruction_ppl[1:0] == 2'b11) begin
            case (opc)
              OPC_R, OPC_I, OPC_LUI, OPC_AUIPC: begin
                reg_wr = rd_nz;
                wdata  = ALU_ppl;
              end
              OPC_J, OPC_JALR: begin
                reg_wr = rd_nz;
                wdata  = PC_ppl + 32'd4;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          stall    = 1'b1;
          dbus_req = 1'b1;
        end
        RESP: begin
`ifdef MISALIGN_TRAP_EN
          misalign = misal_q;
`endif
          if (misal_q) begin
            reg_wr = 1'b0;
          end else if (err_q) begin
            mem_err = 1'b1;
          end else if (!we_q) begin
            reg_wr = rd_nz;
            wdata  = ld_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = swdata_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: vector table for non-memory write-back, sequences for bus ops.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_ppl, ALU_ppl, rdata2_forwarded_ppl, PC_ppl;
  logic        reg_wr, stall, mem_err, misalign, dbus_req, dbus_we;
  logic [31:0] wdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack, dbus_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          unstable;
  int          busy_n;

  always #5 clk = ~clk;

  mem_writeback #(.TIMEOUT_W(8), .BUS_TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .instruction_ppl      (instruction_ppl),
    .ALU_ppl              (ALU_ppl),
    .rdata2_forwarded_ppl (rdata2_forwarded_ppl),
    .PC_ppl               (PC_ppl),
    .reg_wr               (reg_wr),
    .wdata                (wdata),
    .stall                (stall),
    .mem_err              (mem_err),
    .misalign             (misalign),
    .dbus_req             (dbus_req),
    .dbus_we              (dbus_we),
    .dbus_addr            (dbus_addr),
    .dbus_be              (dbus_be),
    .dbus_wdata           (dbus_wdata),
    .dbus_ack             (dbus_ack),
    .dbus_err             (dbus_err),
    .dbus_rdata           (dbus_rdata)
  );

  function automatic logic [31:0] enc(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {12'h000, 5'd0, f3, rd, opc, 2'b11};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Presents a memory op in IDLE, acks on BUSY cycle ack_at (0 = never), returns in RESP.
  task automatic do_mem(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                        input int ack_at, input logic err, input logic [31:0] rd_data,
                        output int nbusy);
    @(negedge clk);
    instruction_ppl      = ins;
    ALU_ppl              = alu;
    rdata2_forwarded_ppl = rs2;
    #1;
    chk("idle_stall", {31'b0, stall}, 32'd1);
    chk("idle_noreq", {31'b0, dbus_req}, 32'd0);
    nbusy    = 0;
    unstable = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      dbus_ack   = 1'b0;
      dbus_err   = 1'b0;
      dbus_rdata = 32'h0;
      if (!dbus_req) break;
      nbusy++;
      if (!stall) unstable++;
      if (c == 1) begin
        cap_addr = dbus_addr; cap_wdata = dbus_wdata; cap_be = dbus_be; cap_we = dbus_we;
      end else if (dbus_addr !== cap_addr || dbus_wdata !== cap_wdata ||
                   dbus_be !== cap_be || dbus_we !== cap_we) begin
        unstable++;
      end
      if (c == ack_at) begin
        dbus_ack   = 1'b1;
        dbus_err   = err;
        dbus_rdata = rd_data;
      end
    end
    #1;
    chk("busy_stable", unstable, 32'd0);
    chk("resp_stall", {31'b0, stall}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        exp_wr;
    logic [31:0] exp_wd;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{enc(5'b01100, 3'b000, 5'd5), 32'h0000_1234, 32'h0,         1'b1, 32'h0000_1234}; // ADD x5
    vecs[1] = '{enc(5'b11011, 3'b000, 5'd1), 32'h0000_0ABC, 32'h0000_0100, 1'b1, 32'h0000_0104}; // JAL x1
    vecs[2] = '{enc(5'b00100, 3'b000, 5'd0), 32'h0000_0055, 32'h0,         1'b0, 32'h0};         // ADDI x0
    vecs[3] = '{enc(5'b01101, 3'b000, 5'd3), 32'hABCD_E000, 32'h0,         1'b1, 32'hABCD_E000}; // LUI x3
    vecs[4] = '{enc(5'b00101, 3'b000, 5'd4), 32'h1000_0040, 32'h0,         1'b1, 32'h1000_0040}; // AUIPC x4
    vecs[5] = '{enc(5'b11001, 3'b000, 5'd2), 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000}; // JALR x2
    vecs[6] = '{enc(5'b11000, 3'b000, 5'd5), 32'h0000_0001, 32'h0,         1'b0, 32'h0};         // BEQ
    vecs[7] = '{32'h0000_0000,               32'h0000_7777, 32'h0,         1'b0, 32'h0};         // bubble

    rst_n = 1'b0;
    instruction_ppl = vecs[0].ins; ALU_ppl = 32'h1234; PC_ppl = 32'h0; rdata2_forwarded_ppl = 32'h0;
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, dbus_req}, 32'd0);
    chk("rst_be", {28'b0, dbus_be}, 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      instruction_ppl = vecs[i].ins; ALU_ppl = vecs[i].alu; PC_ppl = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_reg_wr", i), {31'b0, reg_wr}, {31'b0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wd);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'd0);
      chk($sformatf("vec%0d_req", i), {31'b0, dbus_req}, 32'd0);
    end

    // SB at byte 3, ack on 2nd BUSY cycle
    do_mem(enc(5'b01000, 3'b000, 5'd0), 32'h0000_2003, 32'h0000_00AB, 2, 1'b0, 32'h0, busy_n);
    chk("sb_busy", busy_n, 32'd2);
    chk("sb_be", {28'b0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    chk("sb_addr", cap_addr, 32'h0000_2000);
    chk("sb_we", {31'b0, cap_we}, 32'd1);
    chk("sb_reg_wr", {31'b0, reg_wr}, 32'd0);

    do_mem(enc(5'b01000, 3'b001, 5'd0), 32'h0000_2002, 32'h1234_CAFE, 1, 1'b0, 32'h0, busy_n);
    chk("sh_be", {28'b0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hCAFE_CAFE);

    do_mem(enc(5'b01000, 3'b010, 5'd0), 32'h0000_2004, 32'h1122_3344, 1, 1'b0, 32'h0, busy_n);
    chk("sw_be", {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h1122_3344);
    chk("sw_addr", cap_addr, 32'h0000_2004);

    // Loads, issued back-to-back
    do_mem(enc(5'b00000, 3'b000, 5'd7), 32'h0000_2002, 32'h0, 1, 1'b0, 32'h0080_0000, busy_n);
    chk("lb_busy", busy_n, 32'd1);
    chk("lb_we", {31'b0, cap_we}, 32'd0);
    chk("lb_reg_wr", {31'b0, reg_wr}, 32'd1);
    chk("lb_wdata", wdata, 32'hFFFF_FF80);
    do_mem(enc(5'b00000, 3'b100, 5'd7), 32'h0000_2002, 32'h0, 1, 1'b0, 32'h0080_0000, busy_n);
    chk("lbu_wdata", wdata, 32'h0000_0080);
    do_mem(enc(5'b00000, 3'b001, 5'd8), 32'h0000_2002, 32'h0, 3, 1'b0, 32'h8001_1234, busy_n);
    chk("lh_busy", busy_n, 32'd3);
    chk("lh_wdata", wdata, 32'hFFFF_8001);
    do_mem(enc(5'b00000, 3'b101, 5'd8), 32'h0000_2000, 32'h0, 1, 1'b0, 32'h8001_1234, busy_n);
    chk("lhu_wdata", wdata, 32'h0000_1234);
    do_mem(enc(5'b00000, 3'b010, 5'd9), 32'h0000_2000, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, busy_n);
    chk("lw_wdata", wdata, 32'hDEAD_BEEF);
    chk("lw_reg_wr", {31'b0, reg_wr}, 32'd1);
    do_mem(enc(5'b00000, 3'b010, 5'd0), 32'h0000_2000, 32'h0, 1, 1'b0, 32'h1234_5678, busy_n);
    chk("lw_x0_reg_wr", {31'b0, reg_wr}, 32'd0);

    // Timeout, then bus error
    do_mem(enc(5'b00000, 3'b010, 5'd5), 32'h0000_2000, 32'h0, 0, 1'b0, 32'h0, busy_n);
    chk("to_busy", busy_n, 32'd4);
    chk("to_mem_err", {31'b0, mem_err}, 32'd1);
    chk("to_reg_wr", {31'b0, reg_wr}, 32'd0);
    do_mem(enc(5'b00000, 3'b010, 5'd5), 32'h0000_2000, 32'h0, 2, 1'b1, 32'h5555_5555, busy_n);
    chk("err_busy", busy_n, 32'd2);
    chk("err_mem_err", {31'b0, mem_err}, 32'd1);
    chk("err_reg_wr", {31'b0, reg_wr}, 32'd0);
    @(negedge clk);
    instruction_ppl = 32'h0;
    #1;
    chk("err_pulse_end", {31'b0, mem_err}, 32'd0);

    // Misaligned word load
    do_mem(enc(5'b00000, 3'b010, 5'd6), 32'h0000_2002, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, busy_n);
`ifdef MISALIGN_TRAP_EN
    chk("mis_busy", busy_n, 32'd0);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_reg_wr", {31'b0, reg_wr}, 32'd0);
    chk("mis_mem_err", {31'b0, mem_err}, 32'd0);
`else
    chk("mis_busy", busy_n, 32'd1);
    chk("mis_addr", cap_addr, 32'h0000_2000);
    chk("mis_be", {28'b0, cap_be}, 32'hF);
    chk("mis_flag", {31'b0, misalign}, 32'd0);
    chk("mis_wdata", wdata, 32'hDEAD_BEEF);
`endif

    // Reset while BUSY drops the request immediately
    @(negedge clk);
    instruction_ppl = enc(5'b01000, 3'b010, 5'd0); ALU_ppl = 32'h0000_3000;
    @(negedge clk); #1;
    chk("rb_req_before", {31'b0, dbus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_req", {31'b0, dbus_req}, 32'd0);
    chk("rb_stall", {31'b0, stall}, 32'd0);
    chk("rb_reg_wr", {31'b0, reg_wr}, 32'd0);
    @(negedge clk);
    instruction_ppl = 32'h0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rb_idle_req", {31'b0, dbus_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
